// File: rtl/cpu_bus_slot_arbiter_pkg.sv
// Shared definitions for the CPU bus slot arbiter: bus widths, phase and grant
// encodings, and the slot-start grant decision.
package cpu_bus_slot_arbiter_pkg;

  localparam int AW_DEF = 13;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    PH_M_ADDR = 2'd0,
    PH_M_STB  = 2'd1,
    PH_S_ADDR = 2'd2,
    PH_S_STB  = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_M    = 2'b01,
    GNT_S    = 2'b10
  } gnt_e;

  // The requester served in the slot now ending still has req high (it drops it in
  // its ack cycle), so it is excluded here to avoid a double transaction.
  function automatic gnt_e pick_grant(input logic owner_s,
                                      input logic m_req,
                                      input logic s_req,
                                      input gnt_e prev,
                                      input logic freeze,
                                      input logic steal_en);
    logic m_ok;
    logic s_ok;
    m_ok       = m_req && (prev != GNT_M);
    s_ok       = s_req && (prev != GNT_S);
    pick_grant = GNT_IDLE;
    if (!freeze) begin
      if (owner_s) begin
        if (s_ok)                  pick_grant = GNT_S;
        else if (steal_en && m_ok) pick_grant = GNT_M;
      end else begin
        if (m_ok)                  pick_grant = GNT_M;
        else if (steal_en && s_ok) pick_grant = GNT_S;
      end
    end
  endfunction

endpackage

// File: rtl/cpu_bus_slot_arbiter_phase_gen.sv
// 2-bit frame phase counter producing the 1H/2H phase bits and the decode that
// marks the cycle before the S slot starts.
module bus_phase_gen
  import cpu_bus_slot_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic clk_1h_o,
  output logic clk_2h_o,
  output logic next_owner_s_o
);

  logic [1:0] ph_q;
  logic [1:0] ph_d;

  always_comb begin
    ph_d = ph_q + 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous and only takes effect on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) ph_q <= PH_M_ADDR;
    else        ph_q <= ph_d;
  end

  assign clk_1h_o       = ph_q[0];
  assign clk_2h_o       = ph_q[1];
  assign next_owner_s_o = (ph_q == PH_M_STB);

endmodule

// File: rtl/cpu_bus_slot_arbiter.sv
// Time-division arbiter giving master and sub CPU one address+strobe slot each per
// 4-cycle frame on the shared bus, with optional stealing of idle slots.
module cpu_bus_slot_arbiter
  import cpu_bus_slot_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter bit STEAL_EN = 1'b1
) (
  input  logic          CLK_6M,
  input  logic          nRESET,
  input  logic          FREEZE,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic          m_ack,
  output logic [DW-1:0] m_rdata,
  input  logic          s_req,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic          s_ack,
  output logic [DW-1:0] s_rdata,
  output logic          CLK_1H,
  output logic          CLK_2H,
  output logic [AW-1:0] BUS_A,
  output logic          nWE,
  output logic [DW-1:0] BUS_DOUT,
  output logic          BUS_DOE,
  input  logic [DW-1:0] BUS_DIN,
  output logic [1:0]    BUS_GNT
);

  logic next_owner_s;

  bus_phase_gen u_phase (
    .clk            (CLK_6M),
    .rst_n          (nRESET),
    .clk_1h_o       (CLK_1H),
    .clk_2h_o       (CLK_2H),
    .next_owner_s_o (next_owner_s)
  );

  gnt_e          gnt_q,     gnt_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic          we_q,      we_d;
  logic [DW-1:0] wdata_q,   wdata_d;
  logic          m_ack_q,   m_ack_d;
  logic          s_ack_q,   s_ack_d;
  logic [DW-1:0] m_rdata_q, m_rdata_d;
  logic [DW-1:0] s_rdata_q, s_rdata_d;

  // CLK_1H high marks the strobe cycle; its closing edge completes the transfer
  // and registers the grant for the next slot.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    m_ack_d   = 1'b0;
    s_ack_d   = 1'b0;
    m_rdata_d = m_rdata_q;
    s_rdata_d = s_rdata_q;
    if (CLK_1H) begin
      if (gnt_q == GNT_M) begin
        m_ack_d = 1'b1;
        if (!we_q) m_rdata_d = BUS_DIN;
      end
      if (gnt_q == GNT_S) begin
        s_ack_d = 1'b1;
        if (!we_q) s_rdata_d = BUS_DIN;
      end
      gnt_d = pick_grant(next_owner_s, m_req, s_req, gnt_q, FREEZE, STEAL_EN);
      we_d  = 1'b0;
      if (gnt_d == GNT_M) begin
        addr_d  = m_addr;
        we_d    = m_we;
        wdata_d = m_wdata;
      end else if (gnt_d == GNT_S) begin
        addr_d  = s_addr;
        we_d    = s_we;
        wdata_d = s_wdata;
      end
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (!nRESET) begin
      gnt_q     <= GNT_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      m_ack_q   <= 1'b0;
      s_ack_q   <= 1'b0;
      m_rdata_q <= '0;
      s_rdata_q <= '0;
    end else begin
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      m_ack_q   <= m_ack_d;
      s_ack_q   <= s_ack_d;
      m_rdata_q <= m_rdata_d;
      s_rdata_q <= s_rdata_d;
    end
  end

  // we_q is cleared for idle slots, so it doubles as the data drive enable.
  assign BUS_A    = addr_q;
  assign BUS_DOUT = wdata_q;
  assign BUS_DOE  = we_q;
  assign nWE      = ~(we_q & CLK_1H);
  assign BUS_GNT  = gnt_q;
  assign m_ack    = m_ack_q;
  assign s_ack    = s_ack_q;
  assign m_rdata  = m_rdata_q;
  assign s_rdata  = s_rdata_q;

endmodule

// File: tb/tb_cpu_bus_slot_arbiter.sv
// Directed bench for cpu_bus_slot_arbiter: reset, M read, S write, alternation,
// slot stealing (with and without STEAL_EN) and FREEZE handling.
module tb_cpu_bus_slot_arbiter;

  logic        clk = 1'b0;
  logic        nRESET;
  logic        FREEZE;
  logic        m_req, m_we, s_req, s_we;
  logic [12:0] m_addr, s_addr;
  logic [7:0]  m_wdata, s_wdata;
  logic        m_ack, s_ack;
  logic [7:0]  m_rdata, s_rdata;
  logic        CLK_1H, CLK_2H, nWE, BUS_DOE;
  logic [12:0] BUS_A;
  logic [7:0]  BUS_DOUT, BUS_DIN;
  logic [1:0]  BUS_GNT;

  logic        ns_s_req;
  logic [12:0] ns_s_addr;
  logic        ns_m_ack, ns_s_ack;
  logic [7:0]  ns_m_rdata, ns_s_rdata;
  logic        ns_1h, ns_2h, ns_nwe, ns_doe;
  logic [12:0] ns_bus_a;
  logic [7:0]  ns_dout;
  logic [1:0]  ns_gnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_bus_slot_arbiter #(.AW(13), .DW(8), .STEAL_EN(1'b1)) u_dut (
    .CLK_6M(clk), .nRESET(nRESET), .FREEZE(FREEZE),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .CLK_1H(CLK_1H), .CLK_2H(CLK_2H), .BUS_A(BUS_A), .nWE(nWE),
    .BUS_DOUT(BUS_DOUT), .BUS_DOE(BUS_DOE), .BUS_DIN(BUS_DIN), .BUS_GNT(BUS_GNT)
  );

  cpu_bus_slot_arbiter #(.AW(13), .DW(8), .STEAL_EN(1'b0)) u_dut_ns (
    .CLK_6M(clk), .nRESET(nRESET), .FREEZE(1'b0),
    .m_req(1'b0), .m_we(1'b0), .m_addr(13'h0), .m_wdata(8'h00),
    .m_ack(ns_m_ack), .m_rdata(ns_m_rdata),
    .s_req(ns_s_req), .s_we(1'b0), .s_addr(ns_s_addr), .s_wdata(8'h00),
    .s_ack(ns_s_ack), .s_rdata(ns_s_rdata),
    .CLK_1H(ns_1h), .CLK_2H(ns_2h), .BUS_A(ns_bus_a), .nWE(ns_nwe),
    .BUS_DOUT(ns_dout), .BUS_DOE(ns_doe), .BUS_DIN(BUS_DIN), .BUS_GNT(ns_gnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nRESET = 1'b0; FREEZE = 1'b0;
    m_req = 1'b1; m_we = 1'b0; m_addr = 13'h1ABC; m_wdata = 8'h00;
    s_req = 1'b0; s_we = 1'b0; s_addr = 13'h0; s_wdata = 8'h00;
    ns_s_req = 1'b0; ns_s_addr = 13'h0055;
    BUS_DIN = 8'h33;

    // Reset held three cycles with m_req high: no ack, bus parked.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_m_ack", m_ack, 0);
      check("rst_gnt", BUS_GNT, 0);
    end
    check("rst_bus_a", BUS_A, 0);
    check("rst_nwe", nWE, 1);
    check("rst_doe", BUS_DOE, 0);
    check("rst_dout", BUS_DOUT, 0);
    check("rst_m_rdata", m_rdata, 0);
    check("rst_ph", {CLK_2H, CLK_1H}, 0);
    nRESET = 1'b1;

    // c1..c4: phases 1,2,3,0; M steals the S slot and is acked at c4.
    tick(); check("ph_c1", {CLK_2H, CLK_1H}, 1);
    tick(); check("ph_c2", {CLK_2H, CLK_1H}, 2);
    check("c2_gnt_steal", BUS_GNT, 2'b01);
    check("c2_bus_a", BUS_A, 13'h1ABC);
    tick(); check("ph_c3", {CLK_2H, CLK_1H}, 3);
    check("c3_m_ack", m_ack, 0);
    tick(); check("c4_m_ack", m_ack, 1);
    check("c4_m_rdata", m_rdata, 8'h33);
    check("c4_gnt_idle", BUS_GNT, 0);
    m_req = 1'b0;
    tick(); check("c5_m_ack", m_ack, 0);

    // M read at 0x1ABC in its own slot.
    tick(); m_req = 1'b1; BUS_DIN = 8'h00;
    tick(); check("c7_gnt_idle", BUS_GNT, 0);
    tick(); check("rd_gnt", BUS_GNT, 2'b01);
    check("rd_a_ph0", BUS_A, 13'h1ABC);
    check("rd_nwe_ph0", nWE, 1);
    check("rd_doe", BUS_DOE, 0);
    m_addr = 13'h0FFF;
    tick(); check("rd_a_ph1", BUS_A, 13'h1ABC);
    check("rd_nwe_ph1", nWE, 1);
    BUS_DIN = 8'h5A;
    tick(); check("rd_m_ack", m_ack, 1);
    check("rd_m_rdata", m_rdata, 8'h5A);
    check("rd_no_regrant", BUS_GNT, 0);
    check("idle_a_hold", BUS_A, 13'h1ABC);
    m_req = 1'b0; BUS_DIN = 8'h00;
    tick(); check("rd_ack_pulse", m_ack, 0);
    check("rd_rdata_hold", m_rdata, 8'h5A);

    // S write 0x0042 <= 0xC3 in its own slot.
    tick(); s_req = 1'b1; s_we = 1'b1; s_addr = 13'h0042; s_wdata = 8'hC3;
    check("c12_gnt_idle", BUS_GNT, 0);
    tick();
    tick(); check("wr_gnt", BUS_GNT, 2'b10);
    check("wr_a", BUS_A, 13'h0042);
    check("wr_doe_ph2", BUS_DOE, 1);
    check("wr_nwe_ph2", nWE, 1);
    s_wdata = 8'h11;
    tick(); check("wr_doe_ph3", BUS_DOE, 1);
    check("wr_nwe_ph3", nWE, 0);
    check("wr_dout", BUS_DOUT, 8'hC3);
    tick(); check("wr_s_ack", s_ack, 1);
    check("wr_nwe_after", nWE, 1);
    check("wr_doe_after", BUS_DOE, 0);
    check("wr_s_rdata", s_rdata, 0);
    s_req = 1'b0; s_we = 1'b0;
    tick(); check("wr_ack_pulse", s_ack, 0);

    // Both requesting continuously: strict alternation.
    m_req = 1'b1; m_we = 1'b0; m_addr = 13'h0100;
    s_req = 1'b1; s_addr = 13'h0200; BUS_DIN = 8'h77;
    tick(); check("alt_gnt_c18", BUS_GNT, 2'b10);
    check("alt_a_c18", BUS_A, 13'h0200);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("alt_gnt", BUS_GNT, CLK_2H ? 2'b10 : 2'b01);
      check("alt_m_ack", m_ack, {CLK_2H, CLK_1H} == 2'd2);
      check("alt_s_ack", s_ack, {CLK_2H, CLK_1H} == 2'd0);
    end
    m_req = 1'b0; s_req = 1'b0;
    tick();
    tick(); check("alt_last_s_ack", s_ack, 1);
    check("alt_last_m_ack", m_ack, 0);

    // Stealing: S seen at M slot start.
    tick();
    tick();
    tick(); s_req = 1'b1; s_addr = 13'h0055; ns_s_req = 1'b1;
    tick(); check("stl_gnt", BUS_GNT, 2'b10);
    check("stl_a", BUS_A, 13'h0055);
    check("ns_no_steal", ns_gnt, 0);
    tick(); BUS_DIN = 8'h9C;
    tick(); check("stl_s_ack", s_ack, 1);
    check("stl_s_rdata", s_rdata, 8'h9C);
    check("stl_no_regrant", BUS_GNT, 0);
    check("ns_gnt_own", ns_gnt, 2'b10);
    check("ns_s_ack_early", ns_s_ack, 0);
    s_req = 1'b0;
    tick(); BUS_DIN = 8'h4D;
    check("stl_ack_pulse", s_ack, 0);
    tick(); check("ns_s_ack", ns_s_ack, 1);
    check("ns_s_rdata", ns_s_rdata, 8'h4D);
    check("stl_rdata_hold", s_rdata, 8'h9C);
    ns_s_req = 1'b0;

    // FREEZE across two frames with both requesting.
    tick();
    FREEZE = 1'b1;
    m_req = 1'b1; m_we = 1'b1; m_addr = 13'h0ABC; m_wdata = 8'h3E;
    s_req = 1'b1; s_we = 1'b0; s_addr = 13'h0333;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("frz_gnt", BUS_GNT, 0);
      check("frz_m_ack", m_ack, 0);
      check("frz_s_ack", s_ack, 0);
    end
    FREEZE = 1'b0;
    tick(); check("unfrz_gnt_s", BUS_GNT, 2'b10);
    FREEZE = 1'b1;
    tick(); check("midslot_frz_gnt", BUS_GNT, 2'b10);
    FREEZE = 1'b0;
    tick(); check("unfrz_s_ack", s_ack, 1);
    check("unfrz_gnt_m", BUS_GNT, 2'b01);
    check("unfrz_doe", BUS_DOE, 1);
    tick(); check("unfrz_nwe", nWE, 0);
    check("unfrz_dout", BUS_DOUT, 8'h3E);
    tick(); check("unfrz_m_ack", m_ack, 1);
    check("unfrz_regrant_s", BUS_GNT, 2'b10);
    m_req = 1'b0; s_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
